// File: rtl/esdi_pkg.sv
// esdi_pkg: shared widths, FSM states and parity helper for the ESDI serial responder.
package esdi_pkg;
    localparam int ESDI_WORD_BITS  = 16;
    localparam int ESDI_FRAME_BITS = 17;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_ACK,
        RESP_WAIT,
        TX_WAIT_REQ,
        TX_ACK,
        COMPLETE
    } esdi_state_t;

    // Bit that makes the XOR of word plus parity equal 1.
    function automatic logic odd_parity(input logic [ESDI_WORD_BITS-1:0] w);
        return ~^w;
    endfunction
endpackage

// File: rtl/esdi_sync_edge.sv
// esdi_sync_edge: multi-flop synchroniser with rise/fall detection on the synchronised level.
module esdi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sr;
    logic              prev;

    // Reset to all ones so a line already high at reset release is not seen as a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr   <= '1;
            prev <= 1'b1;
        end else begin
            sr   <= {sr[STAGES-2:0], d};
            prev <= sr[STAGES-1];
        end
    end

    assign q    = sr[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/esdi_drive_serial_responder.sv
// esdi_drive_serial_responder: drive-side ESDI serial channel, receiving 17-bit commands
// and returning optional 17-bit status words with TRANSFER ACK / COMMAND COMPLETE handling.
module esdi_drive_serial_responder
    import esdi_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      esdi_transfer_req,
    input  logic                      esdi_command_data,
    output logic                      esdi_transfer_ack,
    output logic                      esdi_confstat_data,
    output logic                      esdi_command_complete,
    output logic                      cmd_valid,
    output logic [ESDI_WORD_BITS-1:0] cmd_word,
    input  logic                      resp_valid,
    input  logic                      resp_has_data,
    input  logic [ESDI_WORD_BITS-1:0] resp_word,
    output logic                      parity_error,
    output logic                      timeout_abort
);
    esdi_state_t                state;
    logic [ESDI_FRAME_BITS-1:0] rx_sh;
    logic [ESDI_FRAME_BITS-1:0] tx_sh;
    logic [4:0]                 cnt;
    logic [CNT_W-1:0]           tmo;
    logic                       req_s, req_rise, req_fall, data_s;
    logic                       unused_data_rise, unused_data_fall;
    logic                       timed, expired;

    esdi_sync_edge #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk(clk), .reset(reset), .d(esdi_transfer_req),
        .q(req_s), .rise(req_rise), .fall(req_fall)
    );

    esdi_sync_edge #(.STAGES(SYNC_STAGES)) u_data_sync (
        .clk(clk), .reset(reset), .d(esdi_command_data),
        .q(data_s), .rise(unused_data_rise), .fall(unused_data_fall)
    );

    assign timed   = (state == RX_IDLE && cnt != '0) || state == TX_WAIT_REQ;
    assign expired = timed && !(req_rise || req_fall) && tmo == CNT_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= RX_IDLE;
            rx_sh                 <= '0;
            tx_sh                 <= '0;
            cnt                   <= '0;
            tmo                   <= '0;
            esdi_transfer_ack     <= 1'b0;
            esdi_confstat_data    <= 1'b0;
            esdi_command_complete <= 1'b1;
            cmd_valid             <= 1'b0;
            cmd_word              <= '0;
            parity_error          <= 1'b0;
            timeout_abort         <= 1'b0;
        end else begin
            cmd_valid     <= 1'b0;
            parity_error  <= 1'b0;
            timeout_abort <= 1'b0;
            tmo           <= (timed && !(req_rise || req_fall)) ? tmo + CNT_W'(1) : '0;
            if (expired) begin
                timeout_abort         <= 1'b1;
                cnt                   <= '0;
                esdi_transfer_ack     <= 1'b0;
                esdi_confstat_data    <= 1'b0;
                esdi_command_complete <= 1'b1;
                state                 <= RX_IDLE;
            end else begin
                case (state)
                    RX_IDLE: if (req_rise) begin
                        rx_sh             <= {rx_sh[ESDI_FRAME_BITS-2:0], data_s};
                        cnt               <= cnt + 5'd1;
                        esdi_transfer_ack <= 1'b1;
                        state             <= RX_ACK;
                        if (cnt == '0) esdi_command_complete <= 1'b0;
                    end
                    RX_ACK: if (!req_s) begin
                        esdi_transfer_ack <= 1'b0;
                        if (cnt != 5'(ESDI_FRAME_BITS)) begin
                            state <= RX_IDLE;
                        end else if (^rx_sh) begin
                            cmd_valid <= 1'b1;
                            cmd_word  <= rx_sh[ESDI_FRAME_BITS-1:1];
                            cnt       <= '0;
                            state     <= RESP_WAIT;
                        end else begin
                            parity_error <= 1'b1;
                            state        <= COMPLETE;
                        end
                    end
                    RESP_WAIT: if (resp_valid) begin
                        if (resp_has_data) begin
                            tx_sh              <= {resp_word, odd_parity(resp_word)};
                            esdi_confstat_data <= resp_word[ESDI_WORD_BITS-1];
                            state              <= TX_WAIT_REQ;
                        end else begin
                            state <= COMPLETE;
                        end
                    end
                    TX_WAIT_REQ: if (req_rise) begin
                        esdi_transfer_ack <= 1'b1;
                        state             <= TX_ACK;
                    end
                    TX_ACK: if (!req_s) begin
                        esdi_transfer_ack <= 1'b0;
                        tx_sh             <= tx_sh << 1;
                        cnt               <= cnt + 5'd1;
                        // Next bit goes on the wire as ack drops, well before the next req edge.
                        if (cnt == 5'(ESDI_FRAME_BITS - 1)) begin
                            esdi_confstat_data <= 1'b0;
                            state              <= COMPLETE;
                        end else begin
                            esdi_confstat_data <= tx_sh[ESDI_FRAME_BITS-2];
                            state              <= TX_WAIT_REQ;
                        end
                    end
                    COMPLETE: begin
                        esdi_command_complete <= 1'b1;
                        cnt                   <= '0;
                        state                 <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_esdi_drive_serial_responder.sv
// tb_esdi_drive_serial_responder: controller-side model driving handshakes, with a
// scoreboard of expected commands and expected status bits.
module tb_esdi_drive_serial_responder;
    localparam int SYNC = 2;
    localparam int TMO  = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        esdi_transfer_req = 1'b0;
    logic        esdi_command_data = 1'b0;
    logic        esdi_transfer_ack, esdi_confstat_data, esdi_command_complete;
    logic        cmd_valid, parity_error, timeout_abort;
    logic [15:0] cmd_word;
    logic        resp_valid = 1'b0;
    logic        resp_has_data = 1'b0;
    logic [15:0] resp_word = '0;

    int n_cmp = 0, n_bad = 0;
    int n_valid = 0, n_perr = 0, n_tmo = 0;
    logic [15:0] exp_q[$];
    logic        tx_q[$];
    logic [15:0] sb_exp;

    esdi_drive_serial_responder #(
        .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .CNT_W(17)
    ) dut (
        .clk(clk), .reset(reset),
        .esdi_transfer_req(esdi_transfer_req), .esdi_command_data(esdi_command_data),
        .esdi_transfer_ack(esdi_transfer_ack), .esdi_confstat_data(esdi_confstat_data),
        .esdi_command_complete(esdi_command_complete),
        .cmd_valid(cmd_valid), .cmd_word(cmd_word),
        .resp_valid(resp_valid), .resp_has_data(resp_has_data), .resp_word(resp_word),
        .parity_error(parity_error), .timeout_abort(timeout_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) begin
            n_valid++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL cmd_word: got %h, no command expected", cmd_word);
            end else begin
                sb_exp = exp_q.pop_front();
                if (cmd_word !== sb_exp) begin
                    n_bad++;
                    $display("FAIL cmd_word: got %h, need %h", cmd_word, sb_exp);
                end
            end
        end
        if (parity_error) n_perr++;
        if (timeout_abort) n_tmo++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        int n;
        esdi_command_data = b;
        @(posedge clk); #1;
        esdi_transfer_req = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!esdi_transfer_ack && n < 20);
        n_cmp++;
        if (esdi_transfer_ack !== 1'b1 || n > SYNC + 1) begin
            n_bad++;
            $display("FAIL ack_rise: ack=%b after %0d clk, need 1 within %0d", esdi_transfer_ack, n, SYNC + 1);
        end
        esdi_transfer_req = 1'b0;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (esdi_transfer_ack && n < 20);
        n_cmp++;
        if (esdi_transfer_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_fall: ack=%b after %0d clk, need 0", esdi_transfer_ack, n);
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input logic p);
        logic [15:0] v;
        v = w;
        for (int i = 0; i < 16; i++) begin
            send_bit(v[15-i]);
            if (i == 0) begin
                n_cmp++;
                if (esdi_command_complete !== 1'b0) begin
                    n_bad++;
                    $display("FAIL complete_drop: got %b, need 0", esdi_command_complete);
                end
            end
        end
        send_bit(p);
    endtask

    task automatic pulse_resp(input logic has, input logic [15:0] w);
        @(posedge clk); #1;
        resp_valid = 1'b1; resp_has_data = has; resp_word = w;
        @(posedge clk); #1;
        resp_valid = 1'b0; resp_has_data = 1'b0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_tx(input logic [15:0] w, input logic p);
        logic [15:0] v;
        v = w;
        for (int i = 15; i >= 0; i--) tx_q.push_back(v[i]);
        tx_q.push_back(p);
    endtask

    task automatic read_bit(input int idx);
        int n;
        logic d, e;
        @(posedge clk); #1;
        esdi_transfer_req = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!esdi_transfer_ack && n < 20);
        d = esdi_confstat_data;
        e = (tx_q.size() != 0) ? tx_q.pop_front() : 1'bx;
        n_cmp++;
        if (esdi_transfer_ack !== 1'b1 || d !== e) begin
            n_bad++;
            $display("FAIL tx_bit[%0d]: data=%b ack=%b, need data=%b ack=1", idx, d, esdi_transfer_ack, e);
        end
        wait_clks(2);
        n_cmp++;
        if (esdi_confstat_data !== d) begin
            n_bad++;
            $display("FAIL tx_stable[%0d]: got %b, need %b", idx, esdi_confstat_data, d);
        end
        esdi_transfer_req = 1'b0;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (esdi_transfer_ack && n < 20);
        n_cmp++;
        if (esdi_transfer_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL tx_ack_fall[%0d]: got %b, need 0", idx, esdi_transfer_ack);
        end
    endtask

    task automatic test_reset;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (esdi_transfer_ack !== 1'b0 || esdi_command_complete !== 1'b1 || esdi_confstat_data !== 1'b0 ||
            cmd_valid !== 1'b0 || cmd_word !== 16'h0 || parity_error !== 1'b0 || timeout_abort !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: ack=%b cc=%b cs=%b v=%b w=%h pe=%b to=%b, need 0 1 0 0 0000 0 0",
                     esdi_transfer_ack, esdi_command_complete, esdi_confstat_data, cmd_valid, cmd_word,
                     parity_error, timeout_abort);
        end
        wait_clks(1000);
        n_cmp++;
        if (n_valid != 0 || n_perr != 0 || n_tmo != 0 || esdi_command_complete !== 1'b1 || esdi_transfer_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL idle: valid=%0d perr=%0d tmo=%0d cc=%b ack=%b, need 0 0 0 1 0",
                     n_valid, n_perr, n_tmo, esdi_command_complete, esdi_transfer_ack);
        end
    endtask

    task automatic test_cmd_no_data;
        int n, v0;
        v0 = n_valid;
        exp_q.push_back(16'h0900);
        send_frame(16'h0900, 1'b1);
        wait_clks(1);
        n_cmp++;
        if (n_valid != v0 + 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL cmd_valid_count: got %0d pulses, need 1", n_valid - v0);
        end
        pulse_resp(1'b0, 16'h0);
        n = 0;
        while (esdi_command_complete !== 1'b1 && n < 3) begin @(posedge clk); n++; @(negedge clk); end
        n_cmp++;
        if (esdi_command_complete !== 1'b1 || n > 2) begin
            n_bad++;
            $display("FAIL complete_no_data: cc=%b after %0d clk, need 1 within 2", esdi_command_complete, n);
        end
    endtask

    task automatic test_parity_error;
        int v0, p0;
        v0 = n_valid; p0 = n_perr;
        send_frame(16'h0900, 1'b0);
        wait_clks(3);
        n_cmp++;
        if (n_perr != p0 + 1 || n_valid != v0 || esdi_command_complete !== 1'b1) begin
            n_bad++;
            $display("FAIL parity_error: perr=%0d valid=%0d cc=%b, need 1 0 1",
                     n_perr - p0, n_valid - v0, esdi_command_complete);
        end
    endtask

    task automatic test_status_tx;
        exp_q.push_back(16'h0001);
        send_frame(16'h0001, 1'b0);
        pulse_resp(1'b1, 16'hA5C3);
        push_tx(16'hA5C3, 1'b1);
        for (int i = 0; i < 17; i++) read_bit(i);
        wait_clks(2);
        n_cmp++;
        if (esdi_command_complete !== 1'b1 || esdi_confstat_data !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL tx_done: cc=%b cs=%b pending=%0d, need 1 0 0",
                     esdi_command_complete, esdi_confstat_data, exp_q.size());
        end
    endtask

    task automatic test_timeout;
        int t0, v0, n;
        logic [4:0] bits;
        t0 = n_tmo; v0 = n_valid;
        bits = 5'b10110;
        for (int i = 4; i >= 0; i--) send_bit(bits[i]);
        n = 0;
        while (n_tmo == t0 && n < TMO + 50) begin @(posedge clk); n++; @(negedge clk); end
        wait_clks(1);
        n_cmp++;
        if (n_tmo != t0 + 1 || esdi_command_complete !== 1'b1 || n_valid != v0 || n < TMO - 10) begin
            n_bad++;
            $display("FAIL timeout: pulses=%0d cc=%b valid=%0d after %0d clk, need 1 1 0 near %0d",
                     n_tmo - t0, esdi_command_complete, n_valid - v0, n, TMO);
        end
        exp_q.push_back(16'h1234);
        send_frame(16'h1234, 1'b0);
        wait_clks(1);
        n_cmp++;
        if (n_valid != v0 + 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL post_timeout_cmd: got %0d pulses, need 1", n_valid - v0);
        end
        pulse_resp(1'b0, 16'h0);
        wait_clks(2);
    endtask

    task automatic test_reset_mid_tx;
        int n, v0;
        exp_q.push_back(16'h0001);
        send_frame(16'h0001, 1'b0);
        pulse_resp(1'b1, 16'hA5C3);
        push_tx(16'hA5C3, 1'b1);
        for (int i = 0; i < 8; i++) read_bit(i);
        @(posedge clk); #1;
        esdi_transfer_req = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!esdi_transfer_ack && n < 20);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (esdi_transfer_ack !== 1'b0 || esdi_confstat_data !== 1'b0 || esdi_command_complete !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_tx: ack=%b cs=%b cc=%b, need 0 0 1",
                     esdi_transfer_ack, esdi_confstat_data, esdi_command_complete);
        end
        esdi_transfer_req = 1'b0;
        tx_q.delete();
        wait_clks(2);
        reset = 1'b0;
        wait_clks(4);
        v0 = n_valid;
        exp_q.push_back(16'h0900);
        send_frame(16'h0900, 1'b1);
        wait_clks(1);
        n_cmp++;
        if (n_valid != v0 + 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL post_reset_cmd: got %0d pulses, need 1", n_valid - v0);
        end
        pulse_resp(1'b0, 16'h0);
        wait_clks(2);
        n_cmp++;
        if (esdi_command_complete !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_complete: got %b, need 1", esdi_command_complete);
        end
    endtask

    initial begin
        test_reset;
        test_cmd_no_data;
        test_parity_error;
        test_status_tx;
        test_timeout;
        test_reset_mid_tx;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/esdi_drive_serial_responder.md
Name: esdi_drive_serial_responder

Overview:
Drive-side end of the ESDI serial command/status channel. It deserialises 16-bit commands plus odd parity from TRANSFER REQ / COMMAND DATA handshakes, answering each bit with TRANSFER ACK. It hands each command to the drive-emulation logic and, when that logic supplies one, serialises a 16-bit status/configuration word plus parity on CONFIG-STATUS DATA. It drives COMMAND COMPLETE and sits between the cable pins of a drive-emulator build and its command decoder.

Parameters:
SYNC_STAGES, 2, synchroniser flops on esdi_transfer_req and esdi_command_data (min 2)
TIMEOUT_CYCLES, 100000, idle clk cycles mid-word before the bit counter is abandoned
CNT_W, 17, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  single system clock
reset  in  1  synchronous, active-high reset
esdi_transfer_req  in  1  controller TRANSFER REQ, true polarity, asynchronous
esdi_command_data  in  1  controller COMMAND DATA bit, true polarity, asynchronous
esdi_transfer_ack  out  1  TRANSFER ACK to controller
esdi_confstat_data  out  1  CONFIG-STATUS DATA bit to controller
esdi_command_complete  out  1  COMMAND COMPLETE
cmd_valid  out  1  one-cycle pulse: cmd_word holds a parity-good command
cmd_word  out  16  received command, bit 15 = first bit on wire
resp_valid  in  1  one-cycle pulse from drive logic: response decided
resp_has_data  in  1  with resp_valid: 1 = return resp_word, 0 = no data phase
resp_word  in  16  status/config word, sent MSB first
parity_error  out  1  one-cycle pulse: 17-bit command failed odd parity
timeout_abort  out  1  one-cycle pulse: partial word discarded

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. Reset values: esdi_transfer_ack=0, esdi_confstat_data=0, esdi_command_complete=1, cmd_valid=0, cmd_word=0, parity_error=0, timeout_abort=0, FSM=RX_IDLE, bit count=0.
- Inputs: both req and data pass through SYNC_STAGES flops. All decisions use the synchronised values (req_s, data_s).
- FSM states: RX_IDLE, RX_ACK, RESP_WAIT, TX_WAIT_REQ, TX_ACK, COMPLETE.
- RX_IDLE:
  - On a rising req_s, shift data_s into the 17-bit register and increment the bit count.
  - On the first bit (count 0), drop esdi_command_complete to 0.
  - Go to RX_ACK with ack=1 on the next cycle. Latency from req_s rise to ack is 1 clk.
- RX_ACK:
  - Hold ack=1 until req_s=0, then ack=0.
  - If the bit count is below 17, return to RX_IDLE.
  - If the bit count is 17, check parity: XOR of all 17 bits must be 1.
  - Parity good: cmd_valid pulses for one cycle with cmd_word=bits[16:1], then RESP_WAIT.
  - Parity bad: parity_error pulses, no cmd_valid, go to COMPLETE.
- RESP_WAIT:
  - Ignores req_s; esdi_transfer_ack stays 0.
  - On resp_valid with resp_has_data=1: load the 17-bit tx shift register {resp_word, odd parity bit}, go to TX_WAIT_REQ.
  - On resp_valid with resp_has_data=0: go to COMPLETE.
  - resp_valid in any other state is ignored.
- TX_WAIT_REQ:
  - esdi_confstat_data continuously presents the current tx MSB.
  - On a rising req_s, go to TX_ACK and set ack=1. Data is stable at least 1 clk before ack rises and is not changed while ack=1.
- TX_ACK:
  - When req_s=0: ack=0, shift the tx register, increment the count.
  - After the 17th bit, confstat_data=0 and go to COMPLETE; otherwise return to TX_WAIT_REQ.
- COMPLETE: assert esdi_command_complete=1, clear the bit count, go to RX_IDLE (1 clk).
- Timeout:
  - Applies in RX_IDLE with count>0, and in TX_WAIT_REQ.
  - No req_s edge for TIMEOUT_CYCLES → timeout_abort pulses, count cleared, ack=0, command_complete=1, state RX_IDLE.
  - Counter resets on every req_s edge.
- Edge cases:
  - req_s already high on exit from reset is not a rising edge; it needs a low-then-high.
  - A req rise while ack is still 1 is impossible by protocol; it is ignored until req_s falls.
  - Reset mid-word discards all partial state and restores reset values.
  - The parity bit is never exposed on cmd_word.

Decomposition:
- Package esdi_pkg: ESDI_WORD_BITS=16, ESDI_FRAME_BITS=17, FSM state enum, function odd_parity(16-bit) → bit.
- One sub-module, esdi_sync_edge: SYNC_STAGES synchroniser with rise/fall detect. Instantiated for req; used as a plain sync for data.

Test Plan:
- Reset, idle: command_complete=1, ack=0, no pulses for 1000 clk with req held low.
- Send 0x0900 with parity 1 via 17 handshakes:
  - ack follows each req within SYNC_STAGES+1 clk.
  - command_complete falls after bit 1.
  - cmd_valid pulses once with cmd_word=0x0900.
  - Respond resp_valid, resp_has_data=0 → command_complete=1 within 2 clk.
- Send 0x0900 with parity 0 → parity_error pulses once, no cmd_valid, command_complete returns to 1.
- Command 0x0001 (parity 0), then resp_has_data=1 with resp_word=0xA5C3:
  - 17 controller reads yield bits 1010 0101 1100 0011 then parity 1.
  - Data is stable whenever ack=1; command_complete=1 after the final ack fall.
- Send 5 bits then stop for TIMEOUT_CYCLES (short value in sim) → timeout_abort pulses, command_complete=1.
  - A following full command 0x1234 (parity 0) decodes correctly.
- Assert reset during the 9th status bit → ack=0, confstat=0, command_complete=1 next clk, and the next command decodes normally.
